// File: rtl/ps2_pkg.sv
// Shared PS/2 constants, sequencer state encoding and byte classification helpers.
package ps2_pkg;

    localparam int PS2_CODE_W = 16;

    localparam logic [7:0] PS2_BREAK  = 8'hF0;
    localparam logic [7:0] PS2_EXT    = 8'hE0;
    localparam logic [7:0] PS2_ACK    = 8'hFA;
    localparam logic [7:0] PS2_BAT_OK = 8'hAA;
    localparam logic [7:0] PS2_ECHO   = 8'hEE;
    localparam logic [7:0] PS2_RESEND = 8'hFE;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BRK     = 2'd1,
        ST_EXT     = 2'd2,
        ST_EXT_BRK = 2'd3
    } ps2_state_e;

    // Keyboard housekeeping replies that never form part of a scan code.
    function automatic logic is_response(input logic [7:0] b);
        return (b == PS2_ACK) || (b == PS2_BAT_OK) || (b == PS2_ECHO) || (b == PS2_RESEND);
    endfunction

    function automatic logic is_prefix(input logic [7:0] b);
        return (b == PS2_BREAK) || (b == PS2_EXT);
    endfunction

endpackage

// File: rtl/ps2_timeout_timer.sv
// Idle-cycle timer: flags the cycle on which TIMEOUT_CYCLES idle cycles have elapsed.
module ps2_timeout_timer #(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    logic [CNT_W-1:0] count_r;

    // Count idle cycles while enabled; any byte or return to idle restarts from zero.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            count_r <= '0;
        end else if (clear || !enable) begin
            count_r <= '0;
        end else begin
            count_r <= count_r + ONE;
        end
    end

    // Suppressed by clear so a byte landing on the expiry edge takes priority.
    assign expired = enable && !clear && (count_r == LAST);

endmodule

// File: rtl/ps2_code_sequencer.sv
// Assembles PS/2 bytes (F0 / E0 / E0 F0 prefixes) into 16-bit scan-code words with a strobe.
module ps2_code_sequencer
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000,
    parameter bit EMIT_MAKE      = 1'b0
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [7:0]            i_byte,
    input  logic                  i_byte_valid,
    output logic [PS2_CODE_W-1:0] o_code,
    output logic                  o_status,
    output logic                  o_extended,
    output logic                  o_error
);

    ps2_state_e            state_r,    state_nxt_s;
    logic [PS2_CODE_W-1:0] code_r,     code_nxt_s;
    logic                  ext_r,      ext_nxt_s;
    logic                  status_r,   status_nxt_s;
    logic                  error_r,    error_nxt_s;
    logic                  expired_s;

    ps2_timeout_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .clear   (i_byte_valid),
        .enable  (state_r != ST_IDLE),
        .expired (expired_s)
    );

    // Next-state and next-output decode; the incoming byte always outranks a timeout.
    always_comb begin
        state_nxt_s  = state_r;
        code_nxt_s   = code_r;
        ext_nxt_s    = ext_r;
        status_nxt_s = 1'b0;
        error_nxt_s  = 1'b0;
        if (i_byte_valid) begin
            case (state_r)
                ST_IDLE: begin
                    if (i_byte == PS2_BREAK) begin
                        state_nxt_s = ST_BRK;
                    end else if (i_byte == PS2_EXT) begin
                        state_nxt_s = ST_EXT;
                    end else if (is_response(i_byte)) begin
                        state_nxt_s = ST_IDLE;
                    end else if (EMIT_MAKE) begin
                        code_nxt_s   = {8'h00, i_byte};
                        ext_nxt_s    = 1'b0;
                        status_nxt_s = 1'b1;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_BRK: begin
                    if (i_byte == PS2_BREAK) begin
                        error_nxt_s = 1'b1;
                    end else if (i_byte == PS2_EXT) begin
                        error_nxt_s = 1'b1;
                        state_nxt_s = ST_EXT;
                    end else begin
                        code_nxt_s   = {PS2_BREAK, i_byte};
                        ext_nxt_s    = 1'b0;
                        status_nxt_s = 1'b1;
                        state_nxt_s  = ST_IDLE;
                    end
                end
                ST_EXT: begin
                    if (i_byte == PS2_BREAK) begin
                        state_nxt_s = ST_EXT_BRK;
                    end else if (i_byte == PS2_EXT) begin
                        error_nxt_s = 1'b1;
                    end else if (EMIT_MAKE) begin
                        code_nxt_s   = {PS2_EXT, i_byte};
                        ext_nxt_s    = 1'b1;
                        status_nxt_s = 1'b1;
                        state_nxt_s  = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_EXT_BRK: begin
                    if (is_prefix(i_byte)) begin
                        error_nxt_s = 1'b1;
                    end else begin
                        code_nxt_s   = {PS2_BREAK, i_byte};
                        ext_nxt_s    = 1'b1;
                        status_nxt_s = 1'b1;
                    end
                    state_nxt_s = ST_IDLE;
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end else if (expired_s) begin
            state_nxt_s = ST_IDLE;
            error_nxt_s = 1'b1;
        end else begin
            state_nxt_s = state_r;
        end
    end

    // State and registered outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r  <= ST_IDLE;
            code_r   <= 16'h0000;
            ext_r    <= 1'b0;
            status_r <= 1'b0;
            error_r  <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            code_r   <= code_nxt_s;
            ext_r    <= ext_nxt_s;
            status_r <= status_nxt_s;
            error_r  <= error_nxt_s;
        end
    end

    assign o_code     = code_r;
    assign o_extended = ext_r;
    assign o_status   = status_r;
    assign o_error    = error_r;

endmodule

// File: tb/tb_ps2_code_sequencer.sv
// Directed bench: one break-only and one make-enabled sequencer fed the same byte stream.
module tb_ps2_code_sequencer;

    localparam int TO = 8;

    logic        clk;
    logic        rst_n;
    logic [7:0]  byte_s;
    logic        valid_s;
    logic [15:0] code0, code1;
    logic        status0, status1, ext0, ext1, err0, err1;

    int checks   = 0;
    int failures = 0;

    ps2_code_sequencer #(.TIMEOUT_CYCLES(TO), .EMIT_MAKE(1'b0)) u_dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_byte(byte_s), .i_byte_valid(valid_s),
        .o_code(code0), .o_status(status0), .o_extended(ext0), .o_error(err0)
    );

    ps2_code_sequencer #(.TIMEOUT_CYCLES(TO), .EMIT_MAKE(1'b1)) u_dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_byte(byte_s), .i_byte_valid(valid_s),
        .o_code(code1), .o_status(status1), .o_extended(ext1), .o_error(err1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one byte for a single rising edge; returns at the falling edge after it.
    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        byte_s  = b;
        valid_s = 1'b1;
        @(negedge clk);
        valid_s = 1'b0;
    endtask

    initial begin
        logic saw;
        rst_n   = 1'b0;
        byte_s  = 8'h00;
        valid_s = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_code0", 32'(code0), 32'h0000);
        check_eq("rst_status0", 32'(status0), 32'h0);
        check_eq("rst_ext0", 32'(ext0), 32'h0);
        check_eq("rst_err0", 32'(err0), 32'h0);
        rst_n = 1'b1;

        // Plain break sequence
        send_byte(8'hF0);
        check_eq("brk_prefix_nostat", 32'(status0), 32'h0);
        send_byte(8'h16);
        check_eq("brk_status0", 32'(status0), 32'h1);
        check_eq("brk_code0", 32'(code0), 32'hF016);
        check_eq("brk_ext0", 32'(ext0), 32'h0);
        check_eq("brk_code1", 32'(code1), 32'hF016);
        @(negedge clk);
        check_eq("brk_single_pulse", 32'(status0), 32'h0);
        repeat (9) @(negedge clk);
        check_eq("brk_code_held", 32'(code0), 32'hF016);

        // Extended break
        send_byte(8'hE0);
        send_byte(8'hF0);
        check_eq("eb_mid_nostat", 32'(status0), 32'h0);
        send_byte(8'h75);
        check_eq("eb_status0", 32'(status0), 32'h1);
        check_eq("eb_code0", 32'(code0), 32'hF075);
        check_eq("eb_ext0", 32'(ext0), 32'h1);
        @(negedge clk);
        check_eq("eb_single_pulse", 32'(status0), 32'h0);

        // Make codes and response filtering
        send_byte(8'h1C);
        check_eq("mk_status0", 32'(status0), 32'h0);
        check_eq("mk_err0", 32'(err0), 32'h0);
        check_eq("mk_status1", 32'(status1), 32'h1);
        check_eq("mk_code1", 32'(code1), 32'h001C);
        check_eq("mk_ext1", 32'(ext1), 32'h0);
        send_byte(8'hFA);
        check_eq("ack_status1", 32'(status1), 32'h0);
        check_eq("ack_err0", 32'(err0), 32'h0);
        send_byte(8'hAA);
        check_eq("bat_status0", 32'(status0), 32'h0);
        check_eq("bat_status1", 32'(status1), 32'h0);
        check_eq("mk_code0_held", 32'(code0), 32'hF075);

        // Timeout after a lone break prefix
        send_byte(8'hF0);
        saw = 1'b0;
        for (int i = 1; i < TO; i++) begin
            @(negedge clk);
            if (err0) saw = 1'b1;
        end
        check_eq("to_no_early_err", 32'(saw), 32'h0);
        @(negedge clk);
        check_eq("to_err0", 32'(err0), 32'h1);
        check_eq("to_err1", 32'(err1), 32'h1);
        check_eq("to_nostat0", 32'(status0), 32'h0);
        @(negedge clk);
        check_eq("to_err_pulse", 32'(err0), 32'h0);
        send_byte(8'h45);
        check_eq("to_after_status0", 32'(status0), 32'h0);
        check_eq("to_after_err0", 32'(err0), 32'h0);
        check_eq("to_after_code1", 32'(code1), 32'h0045);

        // Byte landing exactly on the expiry edge wins
        send_byte(8'hF0);
        repeat (TO - 2) @(negedge clk);
        send_byte(8'h45);
        check_eq("exp_status0", 32'(status0), 32'h1);
        check_eq("exp_code0", 32'(code0), 32'hF045);
        check_eq("exp_err0", 32'(err0), 32'h0);
        @(negedge clk);
        check_eq("exp_no_late_err", 32'(err0), 32'h0);

        // Back-to-back bytes on consecutive cycles
        @(negedge clk);
        byte_s  = 8'hF0;
        valid_s = 1'b1;
        @(negedge clk);
        byte_s  = 8'h1D;
        @(negedge clk);
        valid_s = 1'b0;
        check_eq("b2b_status0", 32'(status0), 32'h1);
        check_eq("b2b_code0", 32'(code0), 32'hF01D);

        // Malformed F0 E0 F0 3D
        send_byte(8'hF0);
        send_byte(8'hE0);
        check_eq("mal_err0", 32'(err0), 32'h1);
        check_eq("mal_nostat0", 32'(status0), 32'h0);
        send_byte(8'hF0);
        check_eq("mal_err_clear", 32'(err0), 32'h0);
        send_byte(8'h3D);
        check_eq("mal_status0", 32'(status0), 32'h1);
        check_eq("mal_code0", 32'(code0), 32'hF03D);
        check_eq("mal_ext0", 32'(ext0), 32'h1);

        // Asynchronous reset mid-sequence
        send_byte(8'hF0);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_code0", 32'(code0), 32'h0000);
        check_eq("arst_ext0", 32'(ext0), 32'h0);
        check_eq("arst_code1", 32'(code1), 32'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        send_byte(8'h26);
        check_eq("arst_26_status0", 32'(status0), 32'h0);
        check_eq("arst_26_code0", 32'(code0), 32'h0000);
        check_eq("arst_26_err0", 32'(err0), 32'h0);
        check_eq("arst_26_code1", 32'(code1), 32'h0026);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
